bus_arbiter2: RTL and testbench

Two-user arbiter and sequencer for a single shared dual-rail datapath resource in the clockless two-phase fabric. It watches two requester input arrays for completed tokens and grants the resource to one user at a time, round-robin. It forwards the winner's token into the resource, waits for the resource's result token, and routes that result back to the winner only. It sits between two user pipelines and one shared `in`/`out` resource port.

---
 rtl/bus_arbiter2_if.sv | 33 +++
 rtl/bus_arbiter2.sv | 140 ++++++++++++++
 tb/tb_bus_arbiter2.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bus_arbiter2_if.sv
// Bus bundle for the two-user arbiter: both requester ports, both result
// ports, the shared resource port and the status outputs. Every Dual bit is
// two rails, [1] = true rail and [0] = false rail.
`ifndef SIZE
`define SIZE 4
`endif

interface bus_arbiter2_if #(
    parameter int INPUT  = `SIZE,
    parameter int OUTPUT = `SIZE,
    parameter int CNT_W  = 8
);
    logic [INPUT-1:0][1:0]  user0_input;
    logic [INPUT-1:0][1:0]  user1_input;
    logic [OUTPUT-1:0][1:0] user0_output;
    logic [OUTPUT-1:0][1:0] user1_output;
    logic [INPUT-1:0][1:0]  in;
    logic [OUTPUT-1:0][1:0] out;
    logic                   busy;
    logic                   grant;
    logic [CNT_W-1:0]       served0;
    logic [CNT_W-1:0]       served1;

    modport slave (
        input  user0_input, user1_input, out,
        output user0_output, user1_output, in, busy, grant, served0, served1
    );

    modport master (
        output user0_input, user1_input, out,
        input  user0_output, user1_output, in, busy, grant, served0, served1
    );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-user round-robin arbiter/sequencer for one shared dual-rail resource in
// the two-phase fabric. There is no clock: all state moves on the rising edge
// of a completion (done) signal or of reset.
`ifndef SIZE
`define SIZE 4
`endif

// Completion detector: high when every Dual bit has exactly one rail that
// differs from its stored snapshot.
module done #(
    parameter int N = `SIZE
) (
    input  logic [N-1:0][1:0] data,
    input  logic [N-1:0][1:0] snap,
    output logic              complete
);
    logic [N-1:0] bit_new;

    // per-bit token detection: one rail moved, not zero and not both
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bit_new[i] = ^(data[i] ^ snap[i]);
        end
    end

    assign complete = &bit_new;
endmodule

module bus_arbiter2 #(
    parameter int INPUT  = `SIZE,
    parameter int OUTPUT = `SIZE,
    parameter int CNT_W  = 8
) (
    input logic           reset,
    bus_arbiter2_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [INPUT-1:0][1:0]  snap0;
    logic [INPUT-1:0][1:0]  snap1;
    logic [OUTPUT-1:0][1:0] snap_out;
    logic [INPUT-1:0][1:0]  in_r;
    logic [OUTPUT-1:0][1:0] uo0_r;
    logic [OUTPUT-1:0][1:0] uo1_r;
    logic [CNT_W-1:0]       served0_r;
    logic [CNT_W-1:0]       served1_r;
    logic [0:0]             st;
    logic                   grant_r;
    logic                   last;
    logic                   p0;
    logic                   p1;

    logic done0;
    logic done1;
    logic done_out;

    logic retire;
    logic free;
    logic cap0;
    logic cap1;
    logic pend0;
    logic pend1;
    logic do_grant;
    logic win;

    done #(.N(INPUT))  u_done0    (.data(bus.user0_input), .snap(snap0),    .complete(done0));
    done #(.N(INPUT))  u_done1    (.data(bus.user1_input), .snap(snap1),    .complete(done1));
    done #(.N(OUTPUT)) u_done_out (.data(bus.out),         .snap(snap_out), .complete(done_out));

    // Decide this evaluation: retire first, then capture requests, then grant.
    // A request from the user in flight is left un-snapshotted, so its done
    // level stays high and is picked up again once that user retires.
    always_comb begin
        retire   = (st == BUSY) && done_out;
        free     = (st == IDLE) || retire;
        cap0     = done0 && (free || (grant_r != 1'b0));
        cap1     = done1 && (free || (grant_r != 1'b1));
        pend0    = p0 || cap0;
        pend1    = p1 || cap1;
        do_grant = free && (pend0 || pend1);
        win      = (pend0 && pend1) ? ~last : pend1;
    end

    // All sequencing state advances on a completion event or on reset.
    always_ff @(posedge reset or posedge done0 or posedge done1 or posedge done_out) begin
        if (reset) begin
            snap0     <= bus.user0_input;
            snap1     <= bus.user1_input;
            snap_out  <= bus.out;
            in_r      <= '0;
            uo0_r     <= '0;
            uo1_r     <= '0;
            served0_r <= '0;
            served1_r <= '0;
            st        <= IDLE;
            grant_r   <= 1'b0;
            last      <= 1'b1;
            p0        <= 1'b0;
            p1        <= 1'b0;
        end else begin
            if (done_out) begin
                snap_out <= bus.out;
            end
            if (retire) begin
                if (grant_r == 1'b0) begin
                    uo0_r     <= uo0_r ^ (bus.out ^ snap_out);
                    served0_r <= served0_r + CNT_W'(1);
                end else begin
                    uo1_r     <= uo1_r ^ (bus.out ^ snap_out);
                    served1_r <= served1_r + CNT_W'(1);
                end
            end
            p0 <= pend0 && !(do_grant && (win == 1'b0));
            p1 <= pend1 && !(do_grant && (win == 1'b1));
            if (do_grant) begin
                st      <= BUSY;
                grant_r <= win;
                last    <= win;
                if (win == 1'b0) begin
                    in_r  <= in_r ^ (bus.user0_input ^ snap0);
                    snap0 <= bus.user0_input;
                end else begin
                    in_r  <= in_r ^ (bus.user1_input ^ snap1);
                    snap1 <= bus.user1_input;
                end
            end else if (retire) begin
                st <= IDLE;
            end
        end
    end

    assign bus.in           = in_r;
    assign bus.user0_output = uo0_r;
    assign bus.user1_output = uo1_r;
    assign bus.busy         = (st == BUSY);
    assign bus.grant        = grant_r;
    assign bus.served0      = served0_r;
    assign bus.served1      = served1_r;
endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: one instance with 8-bit counters and one
// with 2-bit counters for the wrap case. True rails are the odd bits of each
// flattened token (8'hAA), false rails the even bits (8'h55).
module tb_bus_arbiter2;
    localparam int W = 4;
    localparam logic [2*W-1:0] TR = 8'hAA;
    localparam logic [2*W-1:0] FR = 8'h55;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_in;
    logic [2*W-1:0] exp_uo0;
    logic [2*W-1:0] exp_uo1;
    logic exp_g;

    bus_arbiter2_if #(.INPUT(W), .OUTPUT(W), .CNT_W(8)) bif ();
    bus_arbiter2_if #(.INPUT(W), .OUTPUT(W), .CNT_W(2)) wif ();

    bus_arbiter2 #(.INPUT(W), .OUTPUT(W), .CNT_W(8)) dut (.reset(reset), .bus(bif.slave));
    bus_arbiter2 #(.INPUT(W), .OUTPUT(W), .CNT_W(2)) dut_wrap (.reset(reset), .bus(wif.slave));

    // pacing reference only; the design itself has no clock
    always #5 clk = ~clk;

    task automatic pulse_reset();
        reset = 1'b1;
        #10;
        reset = 1'b0;
        #10;
    endtask

    task automatic test_reset();
        bif.user0_input = 8'h12;
        bif.user1_input = 8'h34;
        bif.out = 8'h56;
        wif.user0_input = 8'h00;
        wif.user1_input = 8'h00;
        wif.out = 8'h00;
        #1;
        reset = 1'b1;
        #10;
        checks++; if (bif.in !== 8'h00) begin errors++; $display("FAIL reset_in: got %h expected 00", bif.in); end
        checks++; if (bif.user0_output !== 8'h00) begin errors++; $display("FAIL reset_uo0: got %h expected 00", bif.user0_output); end
        checks++; if (bif.user1_output !== 8'h00) begin errors++; $display("FAIL reset_uo1: got %h expected 00", bif.user1_output); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bif.busy); end
        checks++; if (bif.grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", bif.grant); end
        checks++; if (bif.served0 !== 8'd0 || bif.served1 !== 8'd0) begin errors++; $display("FAIL reset_served: got %0d/%0d expected 0/0", bif.served0, bif.served1); end
        reset = 1'b0;
        #10;
        checks++; if (bif.in !== 8'h00 || bif.busy !== 1'b0) begin errors++; $display("FAIL reset_release: got in=%h busy=%b expected in=00 busy=0", bif.in, bif.busy); end
    endtask

    task automatic test_single_user0();
        bif.user0_input = bif.user0_input ^ TR;
        #10;
        checks++; if (bif.in !== TR) begin errors++; $display("FAIL single_in: got %h expected %h", bif.in, TR); end
        checks++; if (bif.busy !== 1'b1 || bif.grant !== 1'b0) begin errors++; $display("FAIL single_grant: got busy=%b grant=%b expected 1/0", bif.busy, bif.grant); end
        bif.out = bif.out ^ FR;
        #10;
        checks++; if (bif.user0_output !== FR) begin errors++; $display("FAIL single_uo0: got %h expected %h", bif.user0_output, FR); end
        checks++; if (bif.user1_output !== 8'h00) begin errors++; $display("FAIL single_uo1: got %h expected 00", bif.user1_output); end
        checks++; if (bif.served0 !== 8'd1 || bif.busy !== 1'b0) begin errors++; $display("FAIL single_retire: got served0=%0d busy=%b expected 1/0", bif.served0, bif.busy); end
    endtask

    task automatic test_simultaneous();
        pulse_reset();
        bif.user0_input = bif.user0_input ^ TR;
        bif.user1_input = bif.user1_input ^ FR;
        #10;
        checks++; if (bif.grant !== 1'b0 || bif.in !== TR) begin errors++; $display("FAIL simul_first: got grant=%b in=%h expected 0/%h", bif.grant, bif.in, TR); end
        bif.out = bif.out ^ TR;
        #10;
        checks++; if (bif.user0_output !== TR || bif.served0 !== 8'd1) begin errors++; $display("FAIL simul_retire0: got uo0=%h served0=%0d expected %h/1", bif.user0_output, bif.served0, TR); end
        checks++; if (bif.grant !== 1'b1 || bif.busy !== 1'b1 || bif.in !== 8'hFF) begin errors++; $display("FAIL simul_second: got grant=%b busy=%b in=%h expected 1/1/ff", bif.grant, bif.busy, bif.in); end
        bif.out = bif.out ^ FR;
        #10;
        checks++; if (bif.user1_output !== FR || bif.served1 !== 8'd1 || bif.busy !== 1'b0) begin errors++; $display("FAIL simul_retire1: got uo1=%h served1=%0d busy=%b expected %h/1/0", bif.user1_output, bif.served1, bif.busy, FR); end
        checks++; if (bif.user0_output !== TR) begin errors++; $display("FAIL simul_uo0_quiet: got %h expected %h", bif.user0_output, TR); end
    endtask

    task automatic test_alternation();
        pulse_reset();
        exp_uo0 = 8'h00;
        exp_uo1 = 8'h00;
        bif.user0_input = bif.user0_input ^ TR;
        bif.user1_input = bif.user1_input ^ TR;
        #10;
        exp_in = TR;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 1);
            checks++; if (bif.grant !== exp_g || bif.busy !== 1'b1 || bif.in !== exp_in) begin errors++; $display("FAIL alt_grant%0d: got grant=%b busy=%b in=%h expected %b/1/%h", i, bif.grant, bif.busy, bif.in, exp_g, exp_in); end
            if (i < 4) begin
                if (exp_g == 1'b0) bif.user0_input = bif.user0_input ^ TR;
                else               bif.user1_input = bif.user1_input ^ TR;
                #10;
            end
            bif.out = bif.out ^ FR;
            #10;
            if (exp_g == 1'b0) exp_uo0 = exp_uo0 ^ FR;
            else               exp_uo1 = exp_uo1 ^ FR;
            if (i < 5) exp_in = exp_in ^ TR;
        end
        checks++; if (bif.served0 !== 8'd3 || bif.served1 !== 8'd3) begin errors++; $display("FAIL alt_served: got %0d/%0d expected 3/3", bif.served0, bif.served1); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL alt_idle: got busy=%b expected 0", bif.busy); end
        checks++; if (bif.user0_output !== exp_uo0 || bif.user1_output !== exp_uo1) begin errors++; $display("FAIL alt_outputs: got %h/%h expected %h/%h", bif.user0_output, bif.user1_output, exp_uo0, exp_uo1); end
    endtask

    task automatic test_spurious_and_wrap();
        bif.out = bif.out ^ FR;
        #10;
        checks++; if (bif.user0_output !== exp_uo0 || bif.user1_output !== exp_uo1) begin errors++; $display("FAIL spurious_outputs: got %h/%h expected %h/%h", bif.user0_output, bif.user1_output, exp_uo0, exp_uo1); end
        checks++; if (bif.served0 !== 8'd3 || bif.served1 !== 8'd3 || bif.busy !== 1'b0) begin errors++; $display("FAIL spurious_state: got %0d/%0d busy=%b expected 3/3/0", bif.served0, bif.served1, bif.busy); end
        checks++; if (bif.in !== exp_in) begin errors++; $display("FAIL spurious_in: got %h expected %h", bif.in, exp_in); end
        for (int i = 0; i < 5; i++) begin
            wif.user1_input = wif.user1_input ^ TR;
            #10;
            checks++; if (wif.grant !== 1'b1 || wif.busy !== 1'b1) begin errors++; $display("FAIL wrap_grant%0d: got grant=%b busy=%b expected 1/1", i, wif.grant, wif.busy); end
            wif.out = wif.out ^ FR;
            #10;
        end
        checks++; if (wif.served1 !== 2'd1 || wif.served0 !== 2'd0) begin errors++; $display("FAIL wrap_served: got %0d/%0d expected 0/1", wif.served0, wif.served1); end
        checks++; if (wif.user1_output !== FR || wif.user0_output !== 8'h00) begin errors++; $display("FAIL wrap_outputs: got uo0=%h uo1=%h expected 00/%h", wif.user0_output, wif.user1_output, FR); end
    endtask

    task automatic test_reset_mid();
        bif.user1_input = bif.user1_input ^ TR;
        #10;
        checks++; if (bif.grant !== 1'b1 || bif.busy !== 1'b1 || bif.in !== (exp_in ^ TR)) begin errors++; $display("FAIL mid_grant1: got grant=%b busy=%b in=%h expected 1/1/%h", bif.grant, bif.busy, bif.in, exp_in ^ TR); end
        reset = 1'b1;
        #10;
        checks++; if (bif.busy !== 1'b0 || bif.in !== 8'h00) begin errors++; $display("FAIL mid_reset: got busy=%b in=%h expected 0/00", bif.busy, bif.in); end
        reset = 1'b0;
        #10;
        bif.out = bif.out ^ FR;
        #10;
        checks++; if (bif.user1_output !== 8'h00 || bif.served1 !== 8'd0 || bif.busy !== 1'b0) begin errors++; $display("FAIL mid_late_out: got uo1=%h served1=%0d busy=%b expected 00/0/0", bif.user1_output, bif.served1, bif.busy); end
        bif.user0_input = bif.user0_input ^ TR;
        #10;
        checks++; if (bif.grant !== 1'b0 || bif.busy !== 1'b1 || bif.in !== TR) begin errors++; $display("FAIL mid_regrant: got grant=%b busy=%b in=%h expected 0/1/%h", bif.grant, bif.busy, bif.in, TR); end
        bif.out = bif.out ^ FR;
        #10;
        checks++; if (bif.served0 !== 8'd1 || bif.user0_output !== FR) begin errors++; $display("FAIL mid_retire: got served0=%0d uo0=%h expected 1/%h", bif.served0, bif.user0_output, FR); end
    endtask

    initial begin
        test_reset();
        test_single_user0();
        test_simultaneous();
        test_alternation();
        test_spurious_and_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
